// File: rtl/esm_issue_scheduler.sv
// ESM instruction buffer with lowest-free-slot allocation, round-robin issue of
// IDA-independent slots into a registered valid/ready stage, flush and drain.
module esm_issue_scheduler #(
  parameter int unsigned Instruction_word_size = 32,
  parameter int unsigned bs                    = 16,
  parameter int unsigned IW                    = $clog2(bs)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  input  logic [Instruction_word_size-1:0] in_instr,
  output logic                             in_ready,
  output logic                             alloc_we,
  output logic [IW-1:0]                    alloc_index,
  output logic [0:bs-1]                    valid_entries,
  input  logic [0:bs-1]                    independent_instr,
  output logic                             issue_valid,
  output logic [Instruction_word_size-1:0] issue_instr,
  output logic [IW-1:0]                    issue_index,
  input  logic                             issue_ready,
  input  logic                             flush,
  input  logic                             drain,
  output logic                             drained,
  output logic [IW:0]                      occupancy
);

  localparam int unsigned OW = IW + 1;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    DRAIN   = 2'd1,
    DRAINED = 2'd2
  } state_t;

  state_t                           state;
  logic [IW-1:0]                    rr_ptr;
  logic [Instruction_word_size-1:0] mem [bs];

  logic [0:bs-1] free;
  logic [0:bs-1] cand;
  logic [0:bs-1] valid_nxt;
  logic          free_ok;
  logic [IW-1:0] pick;
  logic          pick_ok;
  logic [IW-1:0] rot_idx;
  logic          load;

  // Allocation, round-robin selection and next occupancy mask.
  always_comb begin
    free        = ~valid_entries;
    cand        = valid_entries & independent_instr;
    alloc_index = '0;
    free_ok     = 1'b0;
    pick        = '0;
    pick_ok     = 1'b0;
    rot_idx     = '0;

    for (int i = 0; i < int'(bs); i++) begin
      if (!free_ok && free[i]) begin
        alloc_index = IW'(i);
        free_ok     = 1'b1;
      end
    end

    // Search starts at rr_ptr; the IW-bit add wraps modulo bs.
    for (int k = 0; k < int'(bs); k++) begin
      rot_idx = rr_ptr + IW'(k);
      if (!pick_ok && cand[rot_idx]) begin
        pick    = rot_idx;
        pick_ok = 1'b1;
      end
    end

    in_ready = rst && (state == RUN) && free_ok && !flush;
    alloc_we = in_valid && in_ready;
    load     = rst && pick_ok && (!issue_valid || issue_ready) && !flush;

    valid_nxt = valid_entries;
    if (alloc_we) valid_nxt[alloc_index] = 1'b1;
    if (load)     valid_nxt[pick]        = 1'b0;
  end

  // Buffer storage; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (alloc_we) mem[alloc_index] <= in_instr;
  end

  // Drain FSM, occupancy, issue stage.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= RUN;
      drained       <= 1'b0;
      valid_entries <= '0;
      occupancy     <= '0;
      rr_ptr        <= '0;
      issue_valid   <= 1'b0;
      issue_instr   <= '0;
      issue_index   <= '0;
    end else begin
      case (state)
        RUN: begin
          if (drain) state <= DRAIN;
        end
        DRAIN: begin
          if (!drain) begin
            state <= RUN;
          end else if (occupancy == '0 && !issue_valid) begin
            state   <= DRAINED;
            drained <= 1'b1;
          end
        end
        DRAINED: begin
          if (!drain) begin
            state   <= RUN;
            drained <= 1'b0;
          end
        end
        default: begin
          state   <= RUN;
          drained <= 1'b0;
        end
      endcase

      if (flush) begin
        valid_entries <= '0;
        occupancy     <= '0;
        rr_ptr        <= '0;
        issue_valid   <= 1'b0;
      end else begin
        valid_entries <= valid_nxt;
        occupancy     <= occupancy + OW'(alloc_we) - OW'(load);
        if (load) begin
          issue_valid <= 1'b1;
          issue_instr <= mem[pick];
          issue_index <= pick;
          rr_ptr      <= pick + IW'(1);
        end else if (issue_valid && issue_ready) begin
          issue_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_esm_issue_scheduler.sv
// Directed table-driven bench for esm_issue_scheduler; each row is one cycle of
// inputs plus the outputs expected before that cycle's rising edge.
module tb_esm_issue_scheduler;

  localparam int unsigned W  = 32;
  localparam int unsigned BS = 16;
  localparam int unsigned IW = 4;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic [W-1:0]  in_instr;
  logic          in_ready;
  logic          alloc_we;
  logic [IW-1:0] alloc_index;
  logic [0:BS-1] valid_entries;
  logic [0:BS-1] independent_instr;
  logic          issue_valid;
  logic [W-1:0]  issue_instr;
  logic [IW-1:0] issue_index;
  logic          issue_ready;
  logic          flush;
  logic          drain;
  logic          drained;
  logic [IW:0]   occupancy;

  int total;
  int bad;

  esm_issue_scheduler dut (
    .clk               (clk),
    .rst               (rst),
    .in_valid          (in_valid),
    .in_instr          (in_instr),
    .in_ready          (in_ready),
    .alloc_we          (alloc_we),
    .alloc_index       (alloc_index),
    .valid_entries     (valid_entries),
    .independent_instr (independent_instr),
    .issue_valid       (issue_valid),
    .issue_instr       (issue_instr),
    .issue_index       (issue_index),
    .issue_ready       (issue_ready),
    .flush             (flush),
    .drain             (drain),
    .drained           (drained),
    .occupancy         (occupancy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          iv;
    int            k;
    logic [0:BS-1] ind;
    logic          ir;
    logic          fl;
    logic          dr;
    logic          rdy;
    logic          we;
    int            aidx;
    logic [0:BS-1] vld;
    logic          ivld;
    int            iidx;
    int            ik;
    int            occ;
    logic          drd;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [W-1:0] word(input int k);
    return {16'hC0DE, 16'(k)};
  endfunction

  // Slots 0..n-1 set.
  function automatic logic [0:BS-1] lo(input int n);
    logic [0:BS-1] m;
    for (int i = 0; i < int'(BS); i++) m[i] = (i < n);
    return m;
  endfunction

  task automatic add(input logic iv, input int k, input logic [0:BS-1] ind,
                     input logic ir, input logic fl, input logic dr,
                     input logic rdy, input logic we, input int aidx,
                     input logic [0:BS-1] vld, input logic ivld, input int iidx,
                     input int ik, input int occ, input logic drd);
    vec_t v;
    v.iv = iv; v.k = k; v.ind = ind; v.ir = ir; v.fl = fl; v.dr = dr;
    v.rdy = rdy; v.we = we; v.aidx = aidx; v.vld = vld; v.ivld = ivld;
    v.iidx = iidx; v.ik = ik; v.occ = occ; v.drd = drd;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, " valid_entries"}, 32'(valid_entries), 32'd0);
    chk({tag, " issue_valid"},   32'(issue_valid),   32'd0);
    chk({tag, " issue_instr"},   32'(issue_instr),   32'd0);
    chk({tag, " issue_index"},   32'(issue_index),   32'd0);
    chk({tag, " occupancy"},     32'(occupancy),     32'd0);
    chk({tag, " drained"},       32'(drained),       32'd0);
  endtask

  localparam logic [0:BS-1] ONES = 16'hFFFF;
  localparam logic [0:BS-1] NONE = 16'h0000;

  initial begin
    total = 0;
    bad   = 0;
    clk   = 1'b0;

    // ---- basic flow: three instructions, everything independent
    add(1, 1, ONES, 1, 0, 0,  1, 1, 0, NONE,                  0, 0, 0, 0, 0);
    add(1, 2, ONES, 1, 0, 0,  1, 1, 1, 16'b1000_0000_0000_0000, 0, 0, 0, 1, 0);
    add(1, 3, ONES, 1, 0, 0,  1, 1, 0, 16'b0100_0000_0000_0000, 1, 0, 1, 1, 0);
    add(0, 0, ONES, 1, 0, 0,  1, 0, 1, 16'b1000_0000_0000_0000, 1, 1, 2, 1, 0);
    add(0, 0, ONES, 1, 0, 0,  1, 0, 0, NONE,                  1, 0, 3, 0, 0);
    add(0, 0, ONES, 1, 0, 0,  1, 0, 0, NONE,                  0, 0, 0, 0, 0);
    // ---- fill all 16 slots with nothing independent
    for (int i = 0; i < int'(BS); i++)
      add(1, 16 + i, NONE, 0, 0, 0,  1, 1, i, lo(i), 0, 0, 0, i, 0);
    add(1, 99, NONE, 0, 0, 0,  0, 0, 0, lo(16), 0, 0, 0, 16, 0);
    add(1, 99, 16'b0000_0100_0000_0000, 0, 0, 0,  0, 0, 0, lo(16), 0, 0, 0, 16, 0);
    add(1, 40, NONE, 0, 0, 0,  1, 1, 5, 16'b1111_1011_1111_1111, 1, 5, 21, 15, 0);
    add(0, 0,  NONE, 0, 0, 0,  0, 0, 0, lo(16), 1, 5, 21, 16, 0);
    // ---- stall: issue stage held while downstream not ready
    for (int i = 0; i < 4; i++)
      add(0, 0, ONES, 0, 0, 0,  0, 0, 0, lo(16), 1, 5, 21, 16, 0);
    // ---- flush a full buffer with an offered instruction and a pending handshake
    add(1, 50, ONES, 1, 1, 0,  0, 0, 0, lo(16), 1, 5, 21, 16, 0);
    add(0, 0,  NONE, 1, 0, 0,  1, 0, 0, NONE,   0, 0, 0, 0, 0);
    // ---- steer rr_ptr to 3 by issuing slot 2
    add(1, 60, NONE, 1, 0, 0,  1, 1, 0, NONE,  0, 0, 0, 0, 0);
    add(1, 61, NONE, 1, 0, 0,  1, 1, 1, lo(1), 0, 0, 0, 1, 0);
    add(1, 62, NONE, 1, 0, 0,  1, 1, 2, lo(2), 0, 0, 0, 2, 0);
    add(0, 0, 16'b0010_0000_0000_0000, 1, 0, 0,  1, 0, 3, lo(3), 0, 0, 0, 3, 0);
    add(1, 70, NONE, 1, 0, 0,  1, 1, 2, lo(2), 1, 2, 62, 2, 0);
    for (int j = 2; j <= 8; j++)
      add(1, 69 + j, NONE, 1, 0, 0,  1, 1, j + 1, lo(j + 1), 0, 0, 0, j + 1, 0);
    // ---- round robin over {2,9} from rr_ptr=3: 9 then wrap to 2
    add(0, 0, 16'b0010_0000_0100_0000, 1, 0, 0,  1, 0, 10, lo(10), 0, 0, 0, 10, 0);
    add(0, 0, 16'b0010_0000_0100_0000, 1, 0, 0,  1, 0, 9, lo(9), 1, 9, 77, 9, 0);
    add(0, 0, 16'b0010_0000_0100_0000, 1, 0, 0,  1, 0, 2, 16'b1101_1111_1000_0000, 1, 2, 70, 8, 0);
    // rr_ptr back at 3: {1,4} must pick 4
    add(0, 0, 16'b0100_1000_0000_0000, 1, 0, 0,  1, 0, 2, 16'b1101_1111_1000_0000, 0, 0, 0, 8, 0);
    // ---- flush with 7 valid, issue pending, in_valid high
    add(1, 80, NONE, 0, 1, 0,  0, 0, 0, 16'b1101_0111_1000_0000, 1, 4, 72, 7, 0);
    add(0, 0,  NONE, 0, 0, 0,  1, 0, 0, NONE, 0, 0, 0, 0, 0);
    // ---- drain with two pending entries
    add(1, 90, NONE, 0, 0, 0,  1, 1, 0, NONE,  0, 0, 0, 0, 0);
    add(1, 91, NONE, 0, 0, 0,  1, 1, 1, lo(1), 0, 0, 0, 1, 0);
    add(0, 0,  NONE, 0, 0, 1,  1, 0, 2, lo(2), 0, 0, 0, 2, 0);
    add(1, 93, NONE, 1, 0, 1,  0, 0, 0, lo(2), 0, 0, 0, 2, 0);
    add(0, 0, 16'b1100_0000_0000_0000, 0, 0, 1,  0, 0, 0, lo(2), 0, 0, 0, 2, 0);
    add(0, 0, 16'b1100_0000_0000_0000, 0, 0, 1,  0, 0, 0, 16'b0100_0000_0000_0000, 1, 0, 90, 1, 0);
    add(0, 0, 16'b1100_0000_0000_0000, 1, 0, 1,  0, 0, 0, 16'b0100_0000_0000_0000, 1, 0, 90, 1, 0);
    add(0, 0, ONES, 1, 0, 1,  0, 0, 0, NONE, 1, 1, 91, 0, 0);
    add(0, 0, ONES, 1, 0, 1,  0, 0, 0, NONE, 0, 0, 0, 0, 0);
    add(0, 0, ONES, 1, 0, 1,  0, 0, 0, NONE, 0, 0, 0, 0, 1);
    add(0, 0, NONE, 1, 0, 0,  0, 0, 0, NONE, 0, 0, 0, 0, 1);
    add(0, 0, NONE, 1, 0, 0,  1, 0, 0, NONE, 0, 0, 0, 0, 0);
    // ---- drain dropped before empty returns to RUN
    add(1, 95, NONE, 1, 0, 1,  1, 1, 0, NONE,  0, 0, 0, 0, 0);
    add(0, 0,  NONE, 1, 0, 0,  0, 0, 0, lo(1), 0, 0, 0, 1, 0);
    add(0, 0,  NONE, 1, 0, 0,  1, 0, 1, lo(1), 0, 0, 0, 1, 0);

    // ---- initial reset, with an instruction offered during reset
    rst               = 1'b0;
    in_valid          = 1'b1;
    in_instr          = word(7);
    independent_instr = ONES;
    issue_ready       = 1'b0;
    flush             = 1'b0;
    drain             = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset in_ready", 32'(in_ready), 32'd0);
    chk("reset alloc_we", 32'(alloc_we), 32'd0);
    check_reset_state("reset");
    rst = 1'b1;

    foreach (vecs[r]) begin
      in_valid          = vecs[r].iv;
      in_instr          = word(vecs[r].k);
      independent_instr = vecs[r].ind;
      issue_ready       = vecs[r].ir;
      flush             = vecs[r].fl;
      drain             = vecs[r].dr;
      #3;
      chk($sformatf("row%0d in_ready", r),      32'(in_ready),      32'(vecs[r].rdy));
      chk($sformatf("row%0d alloc_we", r),      32'(alloc_we),      32'(vecs[r].we));
      if (vecs[r].rdy)
        chk($sformatf("row%0d alloc_index", r), 32'(alloc_index),   32'(vecs[r].aidx));
      chk($sformatf("row%0d valid_entries", r), 32'(valid_entries), 32'(vecs[r].vld));
      chk($sformatf("row%0d issue_valid", r),   32'(issue_valid),   32'(vecs[r].ivld));
      if (vecs[r].ivld) begin
        chk($sformatf("row%0d issue_index", r), 32'(issue_index),   32'(vecs[r].iidx));
        chk($sformatf("row%0d issue_instr", r), issue_instr,        word(vecs[r].ik));
      end
      chk($sformatf("row%0d occupancy", r),     32'(occupancy),     32'(vecs[r].occ));
      chk($sformatf("row%0d drained", r),       32'(drained),       32'(vecs[r].drd));
      @(posedge clk);
      #1;
    end

    // ---- reset mid-operation with an issue pending; slot 0 still holds word 95
    in_valid          = 1'b0;
    independent_instr = ONES;
    issue_ready       = 1'b0;
    flush             = 1'b0;
    drain             = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst pre issue_valid", 32'(issue_valid), 32'd1);
    chk("midrst pre issue_instr", issue_instr,      word(95));
    rst         = 1'b0;
    in_valid    = 1'b1;
    in_instr    = word(123);
    issue_ready = 1'b1;
    flush       = 1'b1;
    #3;
    chk("midrst in_ready", 32'(in_ready), 32'd0);
    chk("midrst alloc_we", 32'(alloc_we), 32'd0);
    @(posedge clk);
    #1;
    check_reset_state("midrst");
    rst      = 1'b1;
    flush    = 1'b0;
    in_valid = 1'b0;
    #3;
    chk("midrst post in_ready", 32'(in_ready), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
